// File: rtl/multicycle_proc.sv
// Multi-cycle AR/T/I/J core: req/ack fetch, FETCH/DECODE/EXEC/WB sequencing.
// Define PROC_BRANCH_ZERO_EN to add the BZ (branch if register zero) opcode.
module multicycle_proc #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [PC_W-1:0] startPC,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic            retire,
    output logic            halted,
    output logic            illegal,
    output logic [PC_W-1:0] dbg_pc
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [4:0] OP_AR   = 5'b00000;
    localparam logic [4:0] OP_T    = 5'b00001;
    localparam logic [4:0] OP_I    = 5'b00010;
    localparam logic [4:0] OP_J    = 5'b00011;
    localparam logic [4:0] OP_BZ   = 5'b00100;
    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rf_d [16];

    logic [4:0]        opcode;
    logic [3:0]        func, rs1, rs2, rd_ar;
    logic              is_ar, is_t, is_i, is_j, is_bz, is_halt;
    logic              illegal_instr;
    logic [DATA_W-1:0] imm_ext, alu_r;
    logic [PC_W-1:0]   jmp_off, br_off;
    logic              req_c, retire_c, halted_c, illegal_c;

    // For T and I the destination shares the rs1 field position.
    assign opcode  = ir_q[31:27];
    assign func    = ir_q[26:23];
    assign rs1     = ir_q[22:19];
    assign rs2     = ir_q[18:15];
    assign rd_ar   = ir_q[14:11];
    assign imm_ext = DATA_W'($signed(ir_q[18:0]));
    assign jmp_off = PC_W'($signed(ir_q[22:0]));
    assign br_off  = PC_W'($signed(ir_q[18:0]));

    assign is_ar   = (opcode == OP_AR);
    assign is_t    = (opcode == OP_T);
    assign is_i    = (opcode == OP_I);
    assign is_j    = (opcode == OP_J);
    assign is_halt = (opcode == OP_HALT);
`ifdef PROC_BRANCH_ZERO_EN
    assign is_bz   = (opcode == OP_BZ);
`else
    assign is_bz   = 1'b0;
`endif

    assign illegal_instr =
        !(is_ar || is_t || is_i || is_j || is_halt || is_bz) ||
        ((is_ar || is_i) && (func > 4'd8));

    always_comb begin
        alu_r = a_q;
        case (func)
            4'd0: alu_r = a_q + b_q;
            4'd1: alu_r = a_q - b_q;
            4'd2: alu_r = a_q & b_q;
            4'd3: alu_r = a_q | b_q;
            4'd4: alu_r = a_q ^ b_q;
            4'd5: alu_r = ~(a_q | b_q);
            4'd6: alu_r = {{(DATA_W-1){1'b0}},
                           ($signed(a_q) < $signed(b_q))};
            4'd7: alu_r = a_q << b_q[4:0];
            4'd8: alu_r = a_q >> b_q[4:0];
            default: alu_r = a_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        rf_d      = rf_q;
        req_c     = 1'b0;
        retire_c  = 1'b0;
        halted_c  = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs1];
                b_d     = is_ar ? rf_q[rs2] : imm_ext;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = is_t ? b_q : alu_r;
                state_d = is_halt ? S_HALT : S_WB;
            end
            S_WB: begin
                if (is_ar) rf_d[rd_ar] = res_q;
                if (is_t || is_i) rf_d[rs1] = res_q;
                pc_d = pc_q + PC_W'(1);
                if (is_j) pc_d = pc_q + PC_W'(1) + jmp_off;
                if (is_bz && (a_q == '0)) pc_d = pc_q + PC_W'(1) + br_off;
                retire_c  = 1'b1;
                illegal_c = illegal_instr;
                state_d   = S_FETCH;
            end
            S_HALT: halted_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_FETCH;
            pc_q    <= startPC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            for (int k = 0; k < 16; k++) rf_q[k] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rf_q    <= rf_d;
        end
    end

    // Outputs are forced low while RESET is held, independent of state.
    assign imem_req  = req_c & ~RESET;
    assign retire    = retire_c & ~RESET;
    assign halted    = halted_c & ~RESET;
    assign illegal   = illegal_c & ~RESET;
    assign imem_addr = pc_q;
    assign dbg_pc    = pc_q;
endmodule

// File: tb/tb_multicycle_proc.sv
// Bench for multicycle_proc: instruction-level reference model plus
// variable-latency memory responder and directed/random programs.
module tb_multicycle_proc;
    logic        clk;
    logic        RESET;
    logic [15:0] startPC;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        retire, halted, illegal;
    logic [15:0] dbg_pc;

    localparam logic [31:0] HALT_W = 32'hF800_0000;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] mem [int];
    int cfg_wait = 0;
    bit force_ack = 0;

    logic [15:0] m_pc;
    logic [31:0] m_rf [16];
    logic [31:0] m_ir;
    int busy = 0;
    bit m_halt = 0;
    bit mvalid = 0;
    int cyc = 0, ret_cnt = 0, ill_cnt = 0;
    int last_ret = 0, prev_ret = 0;

    multicycle_proc dut (
        .CLK(clk), .RESET(RESET), .startPC(startPC),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .retire(retire), .halted(halted), .illegal(illegal),
        .dbg_pc(dbg_pc)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      nm, act, exp, $time);
    endtask

    function automatic logic [31:0] enc_ar(int fn, int a, int b, int d);
        logic [31:0] w = '0;
        w[26:23] = fn[3:0]; w[22:19] = a[3:0];
        w[18:15] = b[3:0];  w[14:11] = d[3:0];
        return w;
    endfunction

    function automatic logic [31:0] enc_ri(int op, int fn, int d, int imm);
        logic [31:0] w = '0;
        w[31:27] = op[4:0]; w[26:23] = fn[3:0];
        w[22:19] = d[3:0];  w[18:0] = imm[18:0];
        return w;
    endfunction

    function automatic logic [31:0] enc_j(int off);
        logic [31:0] w = '0;
        w[31:27] = 5'd3; w[22:0] = off[22:0];
        return w;
    endfunction

    function automatic logic [31:0] rand_word();
        int k = $urandom_range(0, 9);
        int fn = $urandom_range(0, 9);
        int a = $urandom_range(0, 15);
        int b = $urandom_range(0, 15);
        int d = $urandom_range(0, 15);
        int imm = $urandom_range(0, 32'h7FFFF);
        int off = $urandom_range(0, 16) - 8;
        int badop = $urandom_range(5, 30);
        case (k)
            0, 1, 2: return enc_ar(fn, a, b, d);
            3, 9:    return enc_ri(1, fn, d, imm);
            4, 5:    return enc_ri(2, fn, d, imm);
            6:       return enc_j(off);
            7:       return enc_ri(4, 0, d, off);
            default: return enc_ri(badop, fn, d, imm);
        endcase
    endfunction

    function automatic logic [31:0] m_alu(logic [31:0] a, logic [31:0] b,
                                          logic [3:0] fn);
        case (fn)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7: return a << b[4:0];
            8: return a >> b[4:0];
            default: return a;
        endcase
    endfunction

    function automatic bit m_illegal(logic [31:0] w);
        int op = int'(w[31:27]);
        bit known = (op <= 3) || (op == 31);
`ifdef PROC_BRANCH_ZERO_EN
        known = known || (op == 4);
`endif
        return !known || ((op == 0 || op == 2) && w[26:23] > 4'd8);
    endfunction

    function automatic void m_exec(logic [31:0] w);
        int op = int'(w[31:27]);
        logic [31:0] imm = 32'($signed(w[18:0]));
        logic [15:0] nxt = m_pc + 16'd1;
        case (op)
            0: m_rf[w[14:11]] = m_alu(m_rf[w[22:19]], m_rf[w[18:15]], w[26:23]);
            1: m_rf[w[22:19]] = imm;
            2: m_rf[w[22:19]] = m_alu(m_rf[w[22:19]], imm, w[26:23]);
            3: nxt = 16'(int'(m_pc) + 1 + int'($signed(w[22:0])));
`ifdef PROC_BRANCH_ZERO_EN
            4: if (m_rf[w[22:19]] == 0)
                   nxt = 16'(int'(m_pc) + 1 + int'($signed(w[18:0])));
`endif
            default: ;
        endcase
        m_pc = nxt;
    endfunction

    // Reference model advance and per-cycle output comparison.
    initial begin
        forever begin
            bit r, wb, e_req;
            @(negedge clk);
            cyc++;
            r = RESET;
            wb = 0;
            if (r) begin
                m_pc = startPC; busy = 0; m_halt = 0; mvalid = 1;
                for (int i = 0; i < 16; i++) m_rf[i] = '0;
            end else if (mvalid && !m_halt) begin
                case (busy)
                    0: if (imem_ack) begin m_ir = imem_rdata; busy = 1; end
                    1: busy = 2;
                    2: if (m_ir[31:27] == 5'h1F) begin
                           m_halt = 1; busy = 0;
                       end else busy = 3;
                    default: begin m_exec(m_ir); busy = 0; wb = 1; end
                endcase
            end
            if (retire) begin
                ret_cnt++; prev_ret = last_ret; last_ret = cyc;
            end
            if (illegal) ill_cnt++;
            if (mvalid) begin
                e_req = !r && !m_halt && busy == 0;
                chk("imem_req", 64'(imem_req), 64'(e_req));
                if (e_req) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
                chk("dbg_pc", 64'(dbg_pc), 64'(m_pc));
                chk("retire", 64'(retire), 64'(!r && busy == 3));
                chk("illegal", 64'(illegal),
                    64'(!r && busy == 3 && m_illegal(m_ir)));
                chk("halted", 64'(halted), 64'(!r && m_halt));
                if (r || wb)
                    for (int i = 0; i < 16; i++)
                        chk($sformatf("rf%0d", i), 64'(dut.rf_q[i]),
                            64'(m_rf[i]));
            end
        end
    end

    // Memory responder: fixed or random ack latency, junk acks when idle.
    initial begin
        int wait_left = -1;
        imem_ack = 0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            #3;
            if (imem_req) begin
                if (wait_left < 0)
                    wait_left = (cfg_wait < 0) ? $urandom_range(0, 3) : cfg_wait;
                if (wait_left == 0) begin
                    if (!mem.exists(int'(imem_addr)))
                        mem[int'(imem_addr)] = rand_word();
                    imem_ack = 1;
                    imem_rdata = mem[int'(imem_addr)];
                    wait_left = -1;
                end else begin
                    imem_ack = 0;
                    imem_rdata = $urandom;
                    wait_left--;
                end
            end else begin
                wait_left = -1;
                imem_ack = force_ack ? 1'b1 : 1'($urandom_range(0, 1));
                imem_rdata = force_ack ? HALT_W : $urandom;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [15:0] pc, input int n);
        step();
        RESET = 1;
        startPC = pc;
        repeat (n) step();
        RESET = 0;
    endtask

    task automatic run_retires(input int n, input int bound);
        int s = ret_cnt;
        int c = 0;
        while (ret_cnt - s < n && c < bound) begin step(); c++; end
        chk("retire_budget", 64'(ret_cnt - s >= n), 64'(1));
    endtask

    task automatic run_halt(input int bound);
        int c = 0;
        while (!halted && c < bound) begin step(); c++; end
        chk("halt_budget", 64'(halted), 64'(1));
    endtask

    initial begin
        int ill0, hold;
        RESET = 1;
        startPC = 16'h0010;

        // Reset, first fetch, T and AR
        mem[16'h10] = enc_ri(1, 0, 1, 5);
        mem[16'h11] = enc_ri(1, 0, 2, 32'h7FFFD);
        mem[16'h12] = enc_ar(0, 1, 2, 3);
        mem[16'h13] = enc_ar(6, 2, 1, 4);
        mem[16'h14] = HALT_W;
        step();
        RESET = 1;
        startPC = 16'h0010;
        step();
        #1;
        chk("rst_outs", 64'({imem_req, retire, halted, illegal}), 64'(0));
        step();
        RESET = 0;
        #1;
        chk("first_req", 64'(imem_req), 64'(1));
        chk("first_addr", 64'(imem_addr), 64'h10);
        run_halt(100);
        chk("r3_dut", 64'(dut.rf_q[3]), 64'd2);
        chk("r4_dut", 64'(dut.rf_q[4]), 64'd1);
        chk("r3_model", 64'(m_rf[3]), 64'd2);
        chk("cpi4", 64'(last_ret - prev_ret), 64'd4);

        // Wait states and data wrap
        mem.delete();
        cfg_wait = 3;
        mem[16'h50] = enc_ri(1, 0, 5, 32'h7FFFF);
        mem[16'h51] = enc_ri(2, 0, 5, 1);
        mem[16'h52] = HALT_W;
        apply_reset(16'h50, 2);
        run_retires(1, 50);
        step();
        chk("r5_ones", 64'(dut.rf_q[5]), 64'hFFFF_FFFF);
        run_halt(100);
        chk("r5_wrap", 64'(dut.rf_q[5]), 64'd0);
        chk("cpi7", 64'(last_ret - prev_ret), 64'd7);

        // Jump wrap and self-loop
        mem.delete();
        cfg_wait = 0;
        mem[16'hFFFF] = enc_j(1);
        mem[16'h0001] = enc_j(32'h7FFFFF);
        apply_reset(16'hFFFF, 2);
        run_retires(1, 50);
        step();
        chk("jwrap_addr", 64'(imem_addr), 64'h1);
        run_retires(1, 50);
        step();
        chk("jself_addr", 64'(imem_addr), 64'h1);

        // Illegal opcode, then HALT hold
        mem.delete();
        mem[16'h100] = 32'h5000_0000;
        mem[16'h101] = HALT_W;
        apply_reset(16'h100, 2);
        ill0 = ill_cnt;
        run_halt(100);
        chk("illegal_cnt", 64'(ill_cnt - ill0), 64'd1);
        chk("halt_pc", 64'(dbg_pc), 64'h101);
        hold = 0;
        repeat (20) begin
            step();
            if (halted && !imem_req) hold++;
        end
        chk("halt_hold", 64'(hold), 64'd20);

        // Reset during a pending fetch, with stale acks
        mem.delete();
        cfg_wait = 8;
        mem[16'h200] = enc_ri(1, 0, 8, 5);
        mem[16'h300] = enc_ri(1, 0, 8, 1);
        mem[16'h301] = HALT_W;
        apply_reset(16'h200, 2);
        repeat (3) step();
        chk("fetch_pending", 64'(imem_req), 64'(1));
        force_ack = 1;
        RESET = 1;
        startPC = 16'h300;
        cfg_wait = 0;
        step();
        step();
        RESET = 0;
        force_ack = 0;
        #1;
        chk("restart_addr", 64'(imem_addr), 64'h300);
        run_halt(100);
        chk("r8_after", 64'(dut.rf_q[8]), 64'd1);

`ifdef PROC_BRANCH_ZERO_EN
        mem.delete();
        mem[16'h40] = enc_ri(1, 0, 6, 0);
        mem[16'h41] = enc_ri(4, 0, 6, 4);
        mem[16'h46] = enc_ri(1, 0, 6, 7);
        mem[16'h47] = enc_ri(4, 0, 6, 4);
        mem[16'h48] = HALT_W;
        apply_reset(16'h40, 2);
        run_retires(2, 50);
        step();
        chk("bz_taken", 64'(dbg_pc), 64'h46);
        run_halt(100);
        chk("bz_not_taken", 64'(dbg_pc), 64'h48);
`endif

        // Random programs with random ack latency
        mem.delete();
        cfg_wait = -1;
        apply_reset(16'($urandom), 2);
        run_retires(300, 12000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
